// File: rtl/alu_seq.sv
// alu_seq -- sequential WIDTH-bit ALU with valid/ready handshakes.
//
// Purpose:
//   Accepts one operation at a time from the decoder. Single-cycle ops
//   (arithmetic, logic, shifts) are evaluated on the accept edge. MUL runs
//   a shift-add multiplier that retires one multiplier bit per cycle.
//   The result and the Z/N/C/V flags are held until the next operation
//   overwrites them. ADC/SBC consume the registered carry flag.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operation request
//   in_ready   high in IDLE; requests are only taken then
//   op         4-bit opcode (0 ADD .. 10 MUL, 11-15 give zero)
//   a, b       WIDTH-bit operands
//   out_valid  high in DONE; result/flags are valid
//   out_ready  consumer accepts the result (DONE -> IDLE)
//   result     registered WIDTH-bit result
//   flag_z/n/c/v  registered zero, negative, carry, overflow flags
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_ASR = 4'd7;
  localparam logic [3:0] OP_ADC = 4'd8;
  localparam logic [3:0] OP_SBC = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  localparam logic [SHW:0] LAST_ITER = (SHW+1)'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 flag_z_q, flag_z_d;
  logic                 flag_n_q, flag_n_d;
  logic                 flag_c_q, flag_c_d;
  logic                 flag_v_q, flag_v_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [SHW:0]         cnt_q, cnt_d;

  // Single-cycle datapath, evaluated directly from the request inputs.
  logic [WIDTH-1:0]     alu_r;
  logic                 alu_c;
  logic                 alu_v;
  logic [WIDTH-1:0]     b_op;
  logic                 cin;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       shl_w;
  logic [WIDTH:0]       shr_w;
  logic [WIDTH:0]       asr_w;
  logic [SHW-1:0]       sh;
  logic                 add_v;

  always_comb begin
    sh    = b[SHW-1:0];
    b_op  = ((op == OP_SUB) || (op == OP_SBC)) ? ~b : b;
    cin   = 1'b0;
    if (op == OP_SUB) begin
      cin = 1'b1;
    end else if ((op == OP_ADC) || (op == OP_SBC)) begin
      cin = flag_c_q;
    end
    sum   = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    // Adder overflow: operands (after inversion) agree in sign, sum does not.
    add_v = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    // One guard bit on the exit side catches the last bit shifted out;
    // for a zero shift the guard bit stays 0, giving C=0 for free.
    shl_w = {1'b0, a} << sh;
    shr_w = {a, 1'b0} >> sh;
    asr_w = $signed({a, 1'b0}) >>> sh;

    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = add_v;
      end
      OP_AND: alu_r = a & b;
      OP_OR:  alu_r = a | b;
      OP_XOR: alu_r = a ^ b;
      OP_SHL: begin
        alu_r = shl_w[WIDTH-1:0];
        alu_c = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_r = shr_w[WIDTH:1];
        alu_c = shr_w[0];
      end
      OP_ASR: begin
        alu_r = asr_w[WIDTH:1];
        alu_c = asr_w[0];
      end
      default: begin
        alu_r = '0;
      end
    endcase
  end

  // Next-state logic for the FSM and the multiplier.
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    flag_c_d = flag_c_q;
    flag_v_d = flag_v_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
            state_d  = BUSY;
          end else begin
            result_d = alu_r;
            flag_z_d = (alu_r == '0);
            flag_n_d = alu_r[WIDTH-1];
            flag_c_d = alu_c;
            flag_v_d = alu_v;
            state_d  = DONE;
          end
        end
      end
      BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // The final iteration's partial sum is written straight into the
        // result so DONE is reached WIDTH edges after the accept.
        if (cnt_q == LAST_ITER) begin
          result_d = acc_step[WIDTH-1:0];
          flag_z_d = (acc_step[WIDTH-1:0] == '0);
          flag_n_d = acc_step[WIDTH-1];
          flag_c_d = |acc_step[2*WIDTH-1:WIDTH];
          flag_v_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
      flag_c_q <= flag_c_d;
      flag_v_q <= flag_v_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;
  assign flag_c    = flag_c_q;
  assign flag_v    = flag_v_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH=8).
// Directed cases from the feature list followed by randomized operations,
// all compared against an arithmetic reference model of the opcode rules.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic         flag_v;

  int checks = 0;
  int errors = 0;
  bit model_c = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode definitions.
  task automatic model(input int mop, input longint ma, input longint mb, input bit mcin,
                       output longint r, output bit z, output bit n, output bit c, output bit v);
    longint m, half, sa, sb, s, ss, p;
    int sh;
    m    = longint'(1) << W;
    half = m / 2;
    sa   = (ma >= half) ? ma - m : ma;
    sb   = (mb >= half) ? mb - m : mb;
    sh   = int'(mb % W);
    r = 0; c = 0; v = 0;
    case (mop)
      0, 8: begin
        s  = ma + mb + ((mop == 8) ? longint'(mcin) : 0);
        ss = sa + sb + ((mop == 8) ? longint'(mcin) : 0);
        r  = s % m;
        c  = (s >= m);
        v  = (ss >= half) || (ss < -half);
      end
      1, 9: begin
        s  = ma + (m - 1 - mb) + ((mop == 9) ? longint'(mcin) : 1);
        ss = sa - sb - 1 + ((mop == 9) ? longint'(mcin) : 1);
        r  = s % m;
        c  = (s >= m);
        v  = (ss >= half) || (ss < -half);
      end
      2: r = ma & mb;
      3: r = ma | mb;
      4: r = ma ^ mb;
      5: begin
        r = (ma << sh) % m;
        c = (sh != 0) ? bit'((ma >> (W - sh)) & 1) : 1'b0;
      end
      6: begin
        r = ma >> sh;
        c = (sh != 0) ? bit'((ma >> (sh - 1)) & 1) : 1'b0;
      end
      7: begin
        r = (((sa >>> sh) % m) + m) % m;
        c = (sh != 0) ? bit'((ma >> (sh - 1)) & 1) : 1'b0;
      end
      10: begin
        p = ma * mb;
        r = p % m;
        c = ((p / m) != 0);
      end
      default: r = 0;
    endcase
    z = (r == 0);
    n = (r >= half);
  endtask

  // Issue one operation, wait for its result, check it, hold it under
  // backpressure for `hold` cycles, then release it.
  task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int hold, input bit poke);
    longint er;
    bit ez, en, ec, ev;
    int waitc;
    int lat;
    logic [W-1:0] held;
    model(int'(o), longint'(x), longint'(y), model_c, er, ez, en, ec, ev);
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("in_ready_before_accept", in_ready, 1);
    in_valid  = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      if (poke) begin
        // Traffic during BUSY must neither be taken nor disturb the operands.
        in_valid = 1'($urandom_range(0, 1));
        op       = 4'($urandom_range(0, 15));
        a        = W'($urandom);
        b        = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, (o == 4'd10) ? W : 0);
    check("result", result, er);
    check("flags_zncv", {flag_z, flag_n, flag_c, flag_v}, {ez, en, ec, ev});
    $display("op=%0d a=%0h b=%0h -> r=%0h zncv=%b%b%b%b (lat %0d)",
             o, x, y, result, flag_z, flag_n, flag_c, flag_v, lat);
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_result", result, held);
      check("hold_valid_ready", {out_valid, in_ready}, 2'b10);
    end
    model_c = ec;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("released", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;
    #3;
    check("reset_ready_valid", {in_ready, out_valid}, 2'b10);
    check("reset_result", result, 0);
    check("reset_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    do_op(4'd0, 8'h7F, 8'h01, 0, 0);
    check("add7f_const", {result, flag_z, flag_n, flag_c, flag_v}, {8'h80, 4'b0101});
    do_op(4'd0, 8'hFF, 8'h01, 0, 0);
    check("addff_const", {result, flag_z, flag_n, flag_c, flag_v}, {8'h00, 4'b1010});
    do_op(4'd8, 8'h00, 8'h00, 0, 0);
    check("adc_const", {result, flag_c}, {8'h01, 1'b0});
    do_op(4'd1, 8'h80, 8'h01, 0, 0);
    check("sub80_const", {result, flag_c, flag_v}, {8'h7F, 2'b11});
    do_op(4'd1, 8'h01, 8'h02, 0, 0);
    check("sub01_const", {result, flag_n, flag_c}, {8'hFF, 2'b10});
    do_op(4'd9, 8'h10, 8'h01, 0, 0);
    do_op(4'd5, 8'h81, 8'h01, 0, 0);
    check("shl_const", {result, flag_c}, {8'h02, 1'b1});
    do_op(4'd7, 8'h80, 8'h07, 0, 0);
    check("asr_const", {result, flag_c}, {8'hFF, 1'b0});
    do_op(4'd6, 8'hA5, 8'h00, 0, 0);
    check("shr0_const", {result, flag_c}, {8'hA5, 1'b0});
    do_op(4'd6, 8'h03, 8'h01, 0, 0);
    do_op(4'd10, 8'h10, 8'h10, 0, 1);
    check("mul_ovf_const", {result, flag_z, flag_c}, {8'h00, 2'b11});
    do_op(4'd10, 8'h0F, 8'h11, 0, 1);
    check("mul_ff_const", {result, flag_c}, {8'hFF, 1'b0});
    do_op(4'd4, 8'h5A, 8'hFF, 5, 0);
    do_op(4'd12, 8'h12, 8'h34, 0, 0);
    check("op12_const", {result, flag_z, flag_n, flag_c, flag_v}, {8'h00, 4'b1000});

    // Reset in the middle of a multiply: accept, run 3 iterations, abort.
    in_valid = 1'b1;
    op = 4'd10; a = 8'h33; b = 8'h77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midmul_reset_ready_valid", {in_ready, out_valid}, 2'b10);
    check("midmul_reset_result", result, 0);
    check("midmul_reset_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    model_c = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      check("no_valid_after_abort", out_valid, 0);
    end
    out_ready = 1'b0;

    // Randomized operations, chained through the carry flag.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] ro;
      logic [W-1:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      ra = W'($urandom);
      rb = W'($urandom);
      do_op(ro, ra, rb, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
